dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder for the MEM-stage bus: the slave end of the cyc/stb/we/byte-enable
//  handshake driven by the pipeline's memory-stall initiator. Accepts one word request at a
//  time, holds it for LATENCY cycles, then completes it with a single-cycle resp pulse and
//  read data. Stands in for the data cache/physical memory in pipeline simulation and bring-up.
// PARAMETERS
//  DEPTH    256  number of 16-bit words stored; power of two, >= 2
//  LATENCY  2    cycles from request accept edge to resp cycle; >= 1
// PORTS
//  clk           in   1            single clock; all state changes on rising edge
//  reset         in   1            asynchronous, active-high reset
//  dmem_cyc      in   1            bus cycle active
//  dmem_stb      in   1            request strobe; request present when cyc & stb
//  dmem_write    in   1            1 = store, 0 = load
//  dmem_byte_en  in   2            lc3b_mem_wmask; [0] low byte, [1] high byte
//  dmem_address  in   16           lc3b_word byte address; bit 0 ignored for word index
//  dmem_wdata    in   16           lc3b_word store data (lane-aligned by initiator)
//  dmem_resp     out  1            one-cycle completion pulse
//  dmem_rdata    out  16           lc3b_word load data, valid while dmem_resp = 1
//  busy          out  1            request held, not yet completed (debug/perf)
// BEHAVIOUR
//  - Reset (async, active-high): state IDLE, dmem_resp=0, dmem_rdata=16'h0000, busy=0,
//    latency counter=0. Memory array NOT reset (contents undefined until written/preloaded).
//  - States: IDLE, WAIT, RESP. All outputs registered.
//  - IDLE: at edge with cyc&stb=1, latch address, write, byte_en, wdata; load counter with
//    LATENCY-1; go WAIT (LATENCY>1) or RESP (LATENCY==1). busy=1 from that edge.
//  - WAIT: counter decrements each edge; at counter==1 -> RESP. Inputs ignored (initiator may
//    change address mid-stall; latched copy is used).
//  - Entering RESP (same edge): loads read word index adr[log2(DEPTH):1] into dmem_rdata;
//    stores write only lanes with byte_en bit set; dmem_rdata unchanged on stores.
//  - RESP: dmem_resp=1 for exactly one cycle; next edge -> IDLE, busy=0.
//  - Ack timing: request sampled at edge T0 -> dmem_resp high in cycle T0+LATENCY.
//  - Back-to-back: IDLE samples in the cycle after RESP; a still-high stb with the
//    initiator's updated address is a new request (supports two-access indirect ops).
//    Minimum gap between resp pulses = LATENCY+1 cycles.
//  - Abort: cyc=0 at any edge in WAIT -> IDLE, no memory write, no resp. cyc drop during RESP
//    has no effect (transfer already committed).
//  - Address wrap: upper address bits above index are ignored (alias modulo DEPTH words).
//  - byte_en=2'b00 on store: completes with resp, memory unchanged.
//  - Read-after-write to same word in consecutive requests returns new data.
//  - Reset mid-transaction: immediate return to IDLE, resp forced 0, pending store dropped.
// STRUCTURE
//  - lc3b_types (shared package): add dmem_resp_state_t enum {IDLE, WAIT, RESP}; reuse
//    lc3b_word and lc3b_mem_wmask.
//  - Sub-module dmem_byte_array: DEPTH x 2 byte lanes, sync write with per-lane enable,
//    combinational read; optional $readmemh preload file for simulation.
//  - Top holds FSM, latency counter, request latch, rdata register.
// TESTING
//  1. Reset asserted mid-WAIT after store 16'hBEEF to 0x0010 -> resp never pulses; later
//     load 0x0010 does not return BEEF (unless preloaded); outputs 0 during reset.
//  2. LATENCY=2: store 0x1234 to 0x0020 at T0 -> resp in T0+2 only; load 0x0020 -> rdata
//     0x1234 with resp.
//  3. Byte stores: en=2'b01 data 0x00AA to 0x0030, en=2'b10 data 0x5500 to 0x0031 ->
//     load 0x0030 returns 0x55AA; en=2'b00 store leaves 0x55AA.
//  4. Indirect pair: load 0x0040 (holds 0x0050), stb kept high, address switches to 0x0050
//     after first resp -> second resp returns word at 0x0050; two pulses, gap 3 cycles.
//  5. Abort: cyc dropped in WAIT of store 0xFFFF to 0x0060 -> no resp; load 0x0060 unchanged.
//  6. Wrap (DEPTH=256): store 0xCAFE to 0x0202 -> load 0x0002 returns 0xCAFE; LATENCY=1
//     run gives resp in cycle T0+1.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared word/mask types and responder FSM states
package dmem_responder_pkg;
  typedef logic [15:0] lc3b_word;
  typedef logic [1:0] lc3b_mem_wmask;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_resp_state_t;
endpackage

// File: rtl/dmem_byte_array.sv
// dmem_byte_array: DEPTH x 16-bit storage as two byte lanes, sync per-lane write, comb read
module dmem_byte_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [1:0]    we,
  input  logic [AW-1:0] adr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);
  logic [7:0] lo [DEPTH];
  logic [7:0] hi [DEPTH];
  always_ff @(posedge clk) begin
    if (we[0]) lo[adr] <= wdata[7:0];
    if (we[1]) hi[adr] <= wdata[15:8];
  end
  assign rdata = {hi[adr], lo[adr]};
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory slave with fixed LATENCY response
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_cyc,
  input  logic        dmem_stb,
  input  logic        dmem_write,
  input  logic [1:0]  dmem_byte_en,
  input  logic [15:0] dmem_address,
  input  logic [15:0] dmem_wdata,
  output logic        dmem_resp,
  output logic [15:0] dmem_rdata,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  dmem_resp_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [AW-1:0] l_idx, op_idx;
  logic l_we, op_we, req, commit;
  lc3b_mem_wmask l_be, op_be, mem_we;
  lc3b_word l_wdata, op_wdata, mem_rdata;
  logic unused_addr;
  assign unused_addr = &{1'b0, dmem_address[15:AW+1], dmem_address[0]};
  // With LATENCY==1 the access commits on the accept edge, so IDLE uses live inputs
  always_comb begin
    req = dmem_cyc & dmem_stb;
    op_idx = state == IDLE ? dmem_address[AW:1] : l_idx;
    op_we = state == IDLE ? dmem_write : l_we;
    op_be = state == IDLE ? dmem_byte_en : l_be;
    op_wdata = state == IDLE ? dmem_wdata : l_wdata;
    commit = state == IDLE ? req && LATENCY == 1 : state == WAIT && dmem_cyc && cnt == CW'(1);
    mem_we = commit && op_we && !reset ? op_be : 2'b00;
    state_n = state == IDLE ? (req ? (LATENCY == 1 ? RESP : WAIT) : IDLE)
            : state == WAIT ? (!dmem_cyc ? IDLE : cnt == CW'(1) ? RESP : WAIT)
            : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      dmem_resp <= 1'b0;
      dmem_rdata <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= state == WAIT ? cnt - CW'(1) : state == IDLE && req ? CW'(LATENCY - 1) : cnt;
      dmem_resp <= state_n == RESP;
      busy <= state_n != IDLE;
      if (commit && !op_we) dmem_rdata <= mem_rdata;
    end
  end
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      l_idx <= dmem_address[AW:1];
      l_we <= dmem_write;
      l_be <= dmem_byte_en;
      l_wdata <= dmem_wdata;
    end
  end
  dmem_byte_array #(.DEPTH(DEPTH)) u_array (
    .clk(clk),
    .we(mem_we),
    .adr(op_idx),
    .wdata(op_wdata),
    .rdata(mem_rdata)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for two responders (LATENCY 2 and LATENCY 1)
module tb_dmem_responder;
  logic clk = 0, reset = 1, dmem_cyc = 0, dmem_stb = 0, dmem_write = 0, sel = 0;
  logic [1:0] dmem_byte_en = 0;
  logic [15:0] dmem_address = 0, dmem_wdata = 0;
  logic [1:0] resp, busy;
  logic [15:0] rdata [2];
  logic [15:0] lastd [2] = '{16'h0, 16'h0};
  int tests = 0, fails = 0, cycle = 0;
  typedef struct {logic [15:0] d; int mode; int at;} exp_t;
  exp_t q0[$], q1[$];
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;
  dmem_responder #(.DEPTH(256), .LATENCY(2)) dut0 (
    .clk(clk), .reset(reset), .dmem_cyc(dmem_cyc & !sel), .dmem_stb(dmem_stb),
    .dmem_write(dmem_write), .dmem_byte_en(dmem_byte_en), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_resp(resp[0]), .dmem_rdata(rdata[0]), .busy(busy[0]));
  dmem_responder #(.DEPTH(256), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .dmem_cyc(dmem_cyc & sel), .dmem_stb(dmem_stb),
    .dmem_write(dmem_write), .dmem_byte_en(dmem_byte_en), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_resp(resp[1]), .dmem_rdata(rdata[1]), .busy(busy[1]));
  task automatic check(input string n, input logic ok, input logic [15:0] act, input logic [15:0] expv);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %h, required %h", n, act, expv);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (resp[k]) begin
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
          check(k == 0 ? "unexpected resp dut0" : "unexpected resp dut1", 1'b0, 16'h1, 16'h0);
        end else begin
          if (k == 0) e = q0.pop_front();
          else e = q1.pop_front();
          check("resp cycle", cycle == e.at, cycle[15:0], e.at[15:0]);
          if (e.mode == 1) check("rdata", rdata[k] == e.d, rdata[k], e.d);
          else if (e.mode == 2) check("rdata differs from", rdata[k] != e.d, rdata[k], e.d);
        end
      end
    end
  end
  // stores expect rdata to hold the last load value; mode 1 = equal, 2 = must differ
  task automatic req(input logic we, input logic [1:0] be, input logic [15:0] a, input logic [15:0] wd,
                     input logic [15:0] ed, input int mode);
    int l = sel ? 1 : 2;
    exp_t e;
    @(posedge clk); #1;
    dmem_cyc = 1; dmem_stb = 1; dmem_write = we; dmem_byte_en = be; dmem_address = a; dmem_wdata = wd;
    e.d = we ? lastd[sel] : ed;
    e.mode = we ? 1 : mode;
    e.at = cycle + l;
    if (!we && mode == 1) lastd[sel] = ed;
    if (sel) q1.push_back(e);
    else q0.push_back(e);
    @(posedge clk); #1 dmem_stb = 0;
    repeat (l) @(posedge clk);
    #1 dmem_cyc = 0;
  endtask
  initial begin
    int c;
    repeat (2) @(posedge clk);
    #1;
    check("reset resp", resp == 2'b00, {14'h0, resp}, 16'h0);
    check("reset busy", busy == 2'b00, {14'h0, busy}, 16'h0);
    check("reset rdata0", rdata[0] == 16'h0, rdata[0], 16'h0);
    check("reset rdata1", rdata[1] == 16'h0, rdata[1], 16'h0);
    reset = 0;
    @(posedge clk); #1;
    dmem_cyc = 1; dmem_stb = 1; dmem_write = 1; dmem_byte_en = 2'b11; dmem_address = 16'h0010; dmem_wdata = 16'hBEEF;
    @(posedge clk); #1 dmem_stb = 0;
    check("busy in wait", busy[0] == 1'b1, {15'h0, busy[0]}, 16'h1);
    reset = 1;
    #1;
    check("busy in reset", busy[0] == 1'b0, {15'h0, busy[0]}, 16'h0);
    check("resp in reset", resp[0] == 1'b0, {15'h0, resp[0]}, 16'h0);
    @(posedge clk); #1 reset = 0; dmem_cyc = 0;
    req(1, 2'b11, 16'h0020, 16'h1234, 16'h0, 1);
    req(0, 2'b11, 16'h0020, 16'h0, 16'h1234, 1);
    req(1, 2'b01, 16'h0030, 16'h00AA, 16'h0, 1);
    req(1, 2'b10, 16'h0031, 16'h5500, 16'h0, 1);
    req(0, 2'b11, 16'h0030, 16'h0, 16'h55AA, 1);
    req(1, 2'b00, 16'h0030, 16'hFFFF, 16'h0, 1);
    req(0, 2'b11, 16'h0030, 16'h0, 16'h55AA, 1);
    req(1, 2'b11, 16'h0040, 16'h0050, 16'h0, 1);
    req(1, 2'b11, 16'h0050, 16'h7777, 16'h0, 1);
    @(posedge clk); #1;
    dmem_cyc = 1; dmem_stb = 1; dmem_write = 0; dmem_byte_en = 2'b11; dmem_address = 16'h0040;
    c = cycle;
    q0.push_back('{16'h0050, 1, c + 2});
    q0.push_back('{16'h7777, 1, c + 5});
    lastd[0] = 16'h7777;
    repeat (2) @(posedge clk);
    #1 dmem_address = 16'h0050;
    repeat (2) @(posedge clk);
    #1 dmem_stb = 0;
    repeat (2) @(posedge clk);
    #1 dmem_cyc = 0;
    req(1, 2'b11, 16'h0060, 16'h6666, 16'h0, 1);
    @(posedge clk); #1;
    dmem_cyc = 1; dmem_stb = 1; dmem_write = 1; dmem_byte_en = 2'b11; dmem_address = 16'h0060; dmem_wdata = 16'hFFFF;
    @(posedge clk); #1 dmem_stb = 0; dmem_cyc = 0;
    check("busy before abort", busy[0] == 1'b1, {15'h0, busy[0]}, 16'h1);
    repeat (2) @(posedge clk);
    #1 check("busy after abort", busy[0] == 1'b0, {15'h0, busy[0]}, 16'h0);
    req(0, 2'b11, 16'h0060, 16'h0, 16'h6666, 1);
    req(1, 2'b11, 16'h0202, 16'hCAFE, 16'h0, 1);
    req(0, 2'b11, 16'h0002, 16'h0, 16'hCAFE, 1);
    req(0, 2'b11, 16'h0010, 16'h0, 16'hBEEF, 2);
    sel = 1;
    req(1, 2'b11, 16'h0202, 16'hCAFE, 16'h0, 1);
    req(0, 2'b11, 16'h0002, 16'h0, 16'hCAFE, 1);
    req(1, 2'b10, 16'h0003, 16'h1200, 16'h0, 1);
    req(0, 2'b11, 16'h0202, 16'h0, 16'h12FE, 1);
    repeat (5) @(posedge clk);
    #1;
    check("dut0 responses outstanding", q0.size() == 0, q0.size()[15:0], 16'h0);
    check("dut1 responses outstanding", q1.size() == 0, q1.size()[15:0], 16'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
